// File: rtl/decodificador_teclado_parametrizado.sv
// Matrix keypad scanner with press/release debounce, long-press detection and a digit buffer
// supporting backspace, clear-all and enter.
module decodificador_teclado_parametrizado #(
    parameter int unsigned N_LIN           = 4,
    parameter int unsigned N_COL           = 4,
    parameter int unsigned SCAN_CYCLES     = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned HOLD_CYCLES     = 3000000,
    parameter int unsigned MAX_DIGITOS     = 8,
    parameter int unsigned ENTER_KEY       = 15,
    parameter int unsigned CLEAR_KEY       = 14,
    localparam int unsigned KW = $clog2(N_LIN * N_COL),
    localparam int unsigned CW = $clog2(MAX_DIGITOS + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic [N_COL-1:0]          col_matriz_i,
    output logic [N_LIN-1:0]          lin_matriz_o,
    output logic [KW-1:0]             key_code_o,
    output logic                      key_valid_o,
    output logic                      key_long_o,
    output logic [MAX_DIGITOS*KW-1:0] digitos_value_o,
    output logic [CW-1:0]             digitos_count_o,
    output logic                      digitos_valid_o,
    output logic                      buf_full_o
);

    localparam int unsigned RW  = (N_LIN > 1) ? $clog2(N_LIN) : 1;
    localparam int unsigned CIW = (N_COL > 1) ? $clog2(N_COL) : 1;
    localparam int unsigned CNT_MAX =
        (HOLD_CYCLES > DEBOUNCE_CYCLES) ?
            ((HOLD_CYCLES > SCAN_CYCLES) ? HOLD_CYCLES : SCAN_CYCLES) :
            ((DEBOUNCE_CYCLES > SCAN_CYCLES) ? DEBOUNCE_CYCLES : SCAN_CYCLES);
    localparam int unsigned CNTW = $clog2(CNT_MAX + 1);

    localparam logic [CNTW-1:0] SCAN_LAST = CNTW'(SCAN_CYCLES - 1);
    localparam logic [CNTW-1:0] DEB_LAST  = CNTW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_SAT   = CNTW'(CNT_MAX);

    typedef enum logic [2:0] {
        StVarrendo,
        StDebounce,
        StPressionado,
        StLongo,
        StSoltando
    } state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CIW-1:0]    col_q, col_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic [N_COL-1:0]  col_low;
    logic              col_one_hot;
    logic [CIW-1:0]    col_idx;
    logic              key_rel;
    logic [RW-1:0]     row_next;
    logic [CNTW-1:0]   cnt_inc;
    logic              press_evt;
    logic              long_evt;
    logic [KW-1:0]     press_code;
    logic [N_LIN-1:0]  row_onehot;

    logic [KW-1:0]             key_code_q;
    logic                      key_valid_q;
    logic                      key_long_q;
    logic [MAX_DIGITOS*KW-1:0] buf_q, buf_d;
    logic [CW-1:0]             bcnt_q, bcnt_d;
    logic [MAX_DIGITOS*KW-1:0] dval_q, dval_d;
    logic [CW-1:0]             dcnt_q, dcnt_d;
    logic                      dvalid_q, dvalid_d;
    logic                      is_enter, is_clear, full;

    assign col_low     = ~col_matriz_i;
    assign col_one_hot = (col_low != '0) && ((col_low & (col_low - N_COL'(1))) == '0);
    assign key_rel     = col_matriz_i[col_q];
    assign row_next    = (row_q == RW'(N_LIN - 1)) ? '0 : row_q + RW'(1);
    assign cnt_inc     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNTW'(1);
    assign press_code  = KW'(32'(row_q) * N_COL + 32'(col_q));
    assign row_onehot  = N_LIN'(1) << row_q;

    always_comb begin
        col_idx = '0;
        for (int c = 0; c < int'(N_COL); c++) begin
            if (col_low[c]) col_idx = CIW'(c);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StVarrendo;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        if (!enable_i) begin
            state_d = StVarrendo;
            row_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StVarrendo: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_d = '0;
                        if (col_one_hot) begin
                            col_d   = col_idx;
                            state_d = StDebounce;
                        end else begin
                            row_d = row_next;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StDebounce: begin
                    if (key_rel) begin
                        state_d = StVarrendo;
                        row_d   = row_next;
                        cnt_d   = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = StPressionado;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StPressionado: begin
                    if (key_rel) begin
                        state_d = StSoltando;
                        cnt_d   = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = StLongo;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StLongo: begin
                    if (key_rel) begin
                        state_d = StSoltando;
                        cnt_d   = '0;
                    end
                end
                StSoltando: begin
                    // Any low sample restarts the release window.
                    if (!key_rel) begin
                        cnt_d = '0;
                    end else if (cnt_q == DEB_LAST) begin
                        state_d = StVarrendo;
                        row_d   = row_next;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StVarrendo;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        press_evt    = enable_i && (state_q == StDebounce) && !key_rel && (cnt_q == DEB_LAST);
        long_evt     = enable_i && (state_q == StPressionado) && !key_rel &&
                       (cnt_q == HOLD_LAST);
        lin_matriz_o = enable_i ? ~row_onehot : '1;
    end

    assign is_enter = (key_code_q == KW'(ENTER_KEY));
    assign is_clear = (key_code_q == KW'(CLEAR_KEY));
    assign full     = (bcnt_q == CW'(MAX_DIGITOS));

    // Buffer actions run in the cycle the key pulse is visible, so a submit lands one cycle later.
    always_comb begin
        buf_d    = buf_q;
        bcnt_d   = bcnt_q;
        dval_d   = dval_q;
        dcnt_d   = dcnt_q;
        dvalid_d = 1'b0;
        if (key_valid_q) begin
            if (is_enter) begin
                if (bcnt_q != '0) begin
                    dvalid_d = 1'b1;
                    dval_d   = buf_q;
                    dcnt_d   = bcnt_q;
                    buf_d    = '0;
                    bcnt_d   = '0;
                end
            end else if (is_clear) begin
                if (bcnt_q != '0) begin
                    bcnt_d = bcnt_q - CW'(1);
                    for (int i = 0; i < int'(MAX_DIGITOS); i++) begin
                        if (i + 1 == int'(bcnt_q)) buf_d[i*KW +: KW] = '0;
                    end
                end
            end else if (!full) begin
                for (int i = 0; i < int'(MAX_DIGITOS); i++) begin
                    if (i == int'(bcnt_q)) buf_d[i*KW +: KW] = key_code_q;
                end
                bcnt_d = bcnt_q + CW'(1);
            end
        end else if (key_long_q && is_clear) begin
            buf_d  = '0;
            bcnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_long_q  <= 1'b0;
            buf_q       <= '0;
            bcnt_q      <= '0;
            dval_q      <= '0;
            dcnt_q      <= '0;
            dvalid_q    <= 1'b0;
        end else begin
            key_valid_q <= press_evt;
            key_long_q  <= long_evt;
            if (press_evt) key_code_q <= press_code;
            buf_q       <= buf_d;
            bcnt_q      <= bcnt_d;
            dval_q      <= dval_d;
            dcnt_q      <= dcnt_d;
            dvalid_q    <= dvalid_d;
        end
    end

    assign key_code_o      = key_code_q;
    assign key_valid_o     = key_valid_q;
    assign key_long_o      = key_long_q;
    assign digitos_value_o = dval_q;
    assign digitos_count_o = dcnt_q;
    assign digitos_valid_o = dvalid_q;
    assign buf_full_o      = full;

endmodule

// File: tb/tb_decodificador_teclado_parametrizado.sv
// Bench for the keypad decoder: a key-matrix model drives the columns, a digit-queue model
// predicts every submission.
module tb_decodificador_teclado_parametrizado;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [3:0]  col;
    logic [3:0]  lin;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_long;
    logic [15:0] dig_value;
    logic [2:0]  dig_count;
    logic        dig_valid;
    logic        buf_full;

    logic [15:0] pressed = '0;
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int kv_cnt = 0, kv_code = 0, kv_time = 0;
    int kl_cnt = 0, kl_time = 0;
    int dv_cnt = 0, dv_count = 0, dv_time = 0;
    logic [15:0] dv_val = '0;
    int q[$];

    decodificador_teclado_parametrizado #(
        .N_LIN(4), .N_COL(4), .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8), .HOLD_CYCLES(32),
        .MAX_DIGITOS(4), .ENTER_KEY(15), .CLEAR_KEY(14)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .col_matriz_i(col),
        .lin_matriz_o(lin), .key_code_o(key_code), .key_valid_o(key_valid),
        .key_long_o(key_long), .digitos_value_o(dig_value), .digitos_count_o(dig_count),
        .digitos_valid_o(dig_valid), .buf_full_o(buf_full)
    );

    always #5 clk = ~clk;

    // A held key pulls its column low while its row is driven low.
    always_comb begin
        col = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!lin[r] && pressed[r*4+c]) col[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (key_valid) begin
            kv_cnt  <= kv_cnt + 1;
            kv_code <= int'(key_code);
            kv_time <= cyc;
        end
        if (key_long) begin
            kl_cnt  <= kl_cnt + 1;
            kl_time <= cyc;
        end
        if (dig_valid) begin
            dv_cnt   <= dv_cnt + 1;
            dv_val   <= dig_value;
            dv_count <= int'(dig_count);
            dv_time  <= cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Digit-queue model of one registered key (short or long press).
    task automatic model_key(input int code, input bit is_long, output bit exp_dv,
                             output int exp_cnt, output logic [15:0] exp_val);
        exp_dv  = 1'b0;
        exp_cnt = 0;
        exp_val = '0;
        if (code == 15) begin
            if (q.size() > 0) begin
                exp_dv  = 1'b1;
                exp_cnt = q.size();
                foreach (q[i]) exp_val = exp_val | (16'(q[i]) << (4 * i));
                q.delete();
            end
        end else if (code == 14) begin
            if (q.size() > 0) void'(q.pop_back());
            if (is_long) q.delete();
        end else if (q.size() < 4) begin
            q.push_back(code);
        end
    endtask

    // Hold a key until it registers (bounded), keep it hold_after more cycles, release.
    task automatic press(input int code, input int hold_after);
        int s;
        s = kv_cnt;
        pressed = '0;
        pressed[code] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            if (kv_cnt != s) break;
        end
        repeat (hold_after) @(posedge clk);
        pressed = '0;
        repeat (30) @(posedge clk);
    endtask

    task automatic do_key(input int code, input bit is_long, output bit exp_dv,
                          output int exp_cnt, output logic [15:0] exp_val);
        model_key(code, is_long, exp_dv, exp_cnt, exp_val);
        press(code, is_long ? 45 : 5);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        pressed = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({key_code, key_valid, key_long, dig_valid, buf_full} !== 8'h00) begin
            n_err++;
            $display("FAIL reset_flags: got %h want 00",
                     {key_code, key_valid, key_long, dig_valid, buf_full});
        end
        n_vec++;
        if (dig_value !== 16'h0 || dig_count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_digits: got %h/%0d want 0/0", dig_value, dig_count);
        end
        n_vec++;
        if (lin !== 4'b1110) begin
            n_err++;
            $display("FAIL reset_lin: got %b want 1110", lin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_key();
        int s_kv, s_kl;
        bit e; int ec; logic [15:0] ev;
        s_kv = kv_cnt;
        s_kl = kl_cnt;
        model_key(9, 1'b0, e, ec, ev);
        press(9, 12);
        n_vec++;
        if (kv_cnt !== s_kv + 1) begin
            n_err++;
            $display("FAIL single_kv_count: got %0d want %0d", kv_cnt - s_kv, 1);
        end
        n_vec++;
        if (kv_code !== 9) begin
            n_err++;
            $display("FAIL single_code: got %0d want 9", kv_code);
        end
        n_vec++;
        if (kl_cnt !== s_kl) begin
            n_err++;
            $display("FAIL single_no_long: got %0d long pulses want 0", kl_cnt - s_kl);
        end
    endtask

    task automatic test_bounce();
        int s_kv, c, t0;
        bit e; int ec; logic [15:0] ev;
        c = $urandom_range(0, 13);
        s_kv = kv_cnt;
        for (int i = 0; i < 10; i++) begin
            pressed[c] = ~pressed[c];
            repeat (3) @(posedge clk);
        end
        n_vec++;
        if (kv_cnt !== s_kv) begin
            n_err++;
            $display("FAIL bounce_early: got %0d pulses want 0", kv_cnt - s_kv);
        end
        t0 = cyc;
        model_key(c, 1'b0, e, ec, ev);
        press(c, 5);
        n_vec++;
        if (kv_cnt !== s_kv + 1) begin
            n_err++;
            $display("FAIL bounce_count: got %0d want 1", kv_cnt - s_kv);
        end
        n_vec++;
        if (kv_code !== c || kv_time < t0 + 8) begin
            n_err++;
            $display("FAIL bounce_code_time: got code %0d at +%0d want %0d at >= +8",
                     kv_code, kv_time - t0, c);
        end
    endtask

    task automatic test_enter();
        int s_dv;
        bit e; int ec; logic [15:0] ev;
        do_key(15, 1'b0, e, ec, ev);
        do_key(1, 1'b0, e, ec, ev);
        do_key(2, 1'b0, e, ec, ev);
        do_key(3, 1'b0, e, ec, ev);
        s_dv = dv_cnt;
        do_key(15, 1'b0, e, ec, ev);
        n_vec++;
        if (dv_cnt !== s_dv + 1 || dv_count !== 3 || dv_val !== 16'h0321) begin
            n_err++;
            $display("FAIL enter_submit: got %0d pulses cnt %0d val %h want 1 cnt 3 val 0321",
                     dv_cnt - s_dv, dv_count, dv_val);
        end
        n_vec++;
        if (dv_time !== kv_time + 1) begin
            n_err++;
            $display("FAIL enter_latency: got %0d want 1", dv_time - kv_time);
        end
        s_dv = dv_cnt;
        do_key(15, 1'b0, e, ec, ev);
        n_vec++;
        if (dv_cnt !== s_dv) begin
            n_err++;
            $display("FAIL enter_empty: got %0d pulses want 0", dv_cnt - s_dv);
        end
    endtask

    task automatic test_full_backspace();
        int s_dv;
        bit e; int ec; logic [15:0] ev;
        for (int k = 1; k <= 4; k++) do_key(k, 1'b0, e, ec, ev);
        n_vec++;
        if (buf_full !== 1'b1) begin
            n_err++;
            $display("FAIL full_after4: got %b want 1", buf_full);
        end
        do_key(5, 1'b0, e, ec, ev);
        n_vec++;
        if (buf_full !== 1'b1 || kv_code !== 5) begin
            n_err++;
            $display("FAIL full_drop: got full %b code %0d want 1 code 5", buf_full, kv_code);
        end
        do_key(14, 1'b0, e, ec, ev);
        n_vec++;
        if (buf_full !== 1'b0) begin
            n_err++;
            $display("FAIL backspace_full: got %b want 0", buf_full);
        end
        s_dv = dv_cnt;
        do_key(15, 1'b0, e, ec, ev);
        n_vec++;
        if (dv_cnt !== s_dv + 1 || dv_count !== ec || dv_val !== ev || ec !== 3) begin
            n_err++;
            $display("FAIL backspace_submit: got cnt %0d val %h want cnt 3 val %h",
                     dv_count, dv_val, ev);
        end
    endtask

    task automatic test_long_clear();
        int s_kl, s_dv;
        bit e; int ec; logic [15:0] ev;
        for (int k = 0; k < 3; k++) do_key($urandom_range(0, 13), 1'b0, e, ec, ev);
        s_kl = kl_cnt;
        do_key(14, 1'b1, e, ec, ev);
        n_vec++;
        if (kl_cnt !== s_kl + 1 || kl_time - kv_time !== 32) begin
            n_err++;
            $display("FAIL long_clear_pulse: got %0d pulses at +%0d want 1 at +32",
                     kl_cnt - s_kl, kl_time - kv_time);
        end
        s_dv = dv_cnt;
        do_key(15, 1'b0, e, ec, ev);
        n_vec++;
        if (dv_cnt !== s_dv) begin
            n_err++;
            $display("FAIL long_clear_empty: got %0d pulses want 0", dv_cnt - s_dv);
        end
    endtask

    task automatic test_ghost();
        int s_kv;
        s_kv = kv_cnt;
        pressed = 16'h0005;
        repeat (60) @(posedge clk);
        pressed = '0;
        repeat (20) @(posedge clk);
        n_vec++;
        if (kv_cnt !== s_kv) begin
            n_err++;
            $display("FAIL ghost: got %0d pulses want 0", kv_cnt - s_kv);
        end
    endtask

    task automatic test_random();
        int s_kv, s_kl, s_dv, code;
        bit lng, e; int ec; logic [15:0] ev;
        for (int it = 0; it < 24; it++) begin
            code = $urandom_range(0, 15);
            lng = ($urandom_range(0, 3) == 0);
            s_kv = kv_cnt; s_kl = kl_cnt; s_dv = dv_cnt;
            do_key(code, lng, e, ec, ev);
            n_vec++;
            if (kv_cnt !== s_kv + 1 || kv_code !== code) begin
                n_err++;
                $display("FAIL rand_key[%0d]: got %0d pulses code %0d want 1 code %0d",
                         it, kv_cnt - s_kv, kv_code, code);
            end
            n_vec++;
            if (kl_cnt !== s_kl + int'(lng)) begin
                n_err++;
                $display("FAIL rand_long[%0d]: got %0d want %0d", it, kl_cnt - s_kl, lng);
            end
            n_vec++;
            if (dv_cnt !== s_dv + int'(e)) begin
                n_err++;
                $display("FAIL rand_submit[%0d]: got %0d want %0d", it, dv_cnt - s_dv, e);
            end
            if (e) begin
                n_vec++;
                if (dv_count !== ec || dv_val !== ev || dv_time !== kv_time + 1) begin
                    n_err++;
                    $display("FAIL rand_value[%0d]: got %0d/%h at +%0d want %0d/%h at +1",
                             it, dv_count, dv_val, dv_time - kv_time, ec, ev);
                end
            end
            n_vec++;
            if (buf_full !== (q.size() == 4)) begin
                n_err++;
                $display("FAIL rand_full[%0d]: got %b want %b", it, buf_full, q.size() == 4);
            end
        end
    endtask

    task automatic test_mid_reset();
        int s_kv, s_dv;
        bit e; int ec; logic [15:0] ev;
        do_key(7, 1'b0, e, ec, ev);
        do_key(15, 1'b0, e, ec, ev);
        do_key(3, 1'b0, e, ec, ev);
        s_kv = kv_cnt;
        pressed = '0;
        pressed[5] = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            if (kv_cnt != s_kv) break;
        end
        repeat (3) @(posedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({key_code, key_valid, key_long, dig_valid, buf_full} !== 8'h00 ||
            dig_value !== 16'h0 || dig_count !== 3'd0) begin
            n_err++;
            $display("FAIL midreset_outputs: got code %0d val %h cnt %0d want all 0",
                     key_code, dig_value, dig_count);
        end
        n_vec++;
        if (lin !== 4'b1110) begin
            n_err++;
            $display("FAIL midreset_lin: got %b want 1110", lin);
        end
        pressed = '0;
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        s_dv = dv_cnt;
        do_key(15, 1'b0, e, ec, ev);
        n_vec++;
        if (dv_cnt !== s_dv) begin
            n_err++;
            $display("FAIL midreset_buffer: got %0d pulses want 0", dv_cnt - s_dv);
        end
    endtask

    task automatic test_enable_drop();
        int s_kv, s_kl, s_dv;
        bit e; int ec; logic [15:0] ev;
        do_key(8, 1'b0, e, ec, ev);
        do_key(10, 1'b0, e, ec, ev);
        s_kv = kv_cnt;
        s_kl = kl_cnt;
        pressed = '0;
        pressed[6] = 1'b1;
        repeat (5) @(posedge clk);
        enable = 1'b0;
        #1;
        n_vec++;
        if (lin !== 4'b1111) begin
            n_err++;
            $display("FAIL enable_lin: got %b want 1111", lin);
        end
        repeat (60) @(posedge clk);
        pressed = '0;
        repeat (5) @(posedge clk);
        enable = 1'b1;
        repeat (20) @(posedge clk);
        n_vec++;
        if (kv_cnt !== s_kv || kl_cnt !== s_kl) begin
            n_err++;
            $display("FAIL enable_pulses: got %0d/%0d want 0/0", kv_cnt - s_kv, kl_cnt - s_kl);
        end
        s_dv = dv_cnt;
        do_key(15, 1'b0, e, ec, ev);
        n_vec++;
        if (dv_cnt !== s_dv + 1 || dv_count !== 2 || dv_val !== 16'h00A8) begin
            n_err++;
            $display("FAIL enable_retain: got %0d pulses %0d/%h want 1 2/00a8",
                     dv_cnt - s_dv, dv_count, dv_val);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_enter();
        test_full_backspace();
        test_long_clear();
        test_ghost();
        test_random();
        test_mid_reset();
        test_enable_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
